// File: rtl/controller_ram_bist_master.sv
// RAM built-in self-test initiator for the on-chip RAM s1 port (Avalon-MM).
// Writes seed+i to words base..base+N-1, reads them back through a fixed-latency
// pipeline and compares each returned word against seed+i.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               one-cycle request, only honoured in IDLE
//   base_addr           first word address of the test range
//   word_count          number of words to test (0 allowed)
//   seed                pattern value written to word 0
//   busy, done          busy while WRITE/READ/DRAIN; done pulses once at the end
//   pass, range_err     result of the last test, held until the next start
//   error_count         saturating mismatch count of the last test
//   first_fail_addr     address of the first mismatching word
//   address..writedata  RAM s1 command side
//   readdata            RAM s1 read data, valid READ_LATENCY cycles after issue
module controller_ram_bist_master #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DEPTH        = 12288,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              range_err,
    output logic [15:0]       error_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata
);

    localparam logic [ADDR_W:0]         DepthW   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]         OneW     = (ADDR_W + 1)'(1);
    // Marks the exit stage; every other stage must be empty before DRAIN ends.
    localparam logic [READ_LATENCY-1:0] ExitMask = (READ_LATENCY)'(1) << (READ_LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [31:0]       seed_q, seed_d;
    logic              pass_q, pass_d;
    logic              range_err_q, range_err_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
    logic              any_mis_q, any_mis_d;

    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [31:0]             pipe_exp_q  [READ_LATENCY];
    logic [ADDR_W-1:0]       pipe_addr_q [READ_LATENCY];

    logic [ADDR_W:0] end_addr;
    logic [ADDR_W:0] addr_sum;
    logic            range_bad;
    logic            last_idx;
    logic            issue_rd;
    logic            mismatch;
    logic            pending;

    assign end_addr  = {1'b0, base_addr} + word_count;
    assign range_bad = end_addr > DepthW;
    assign last_idx  = idx_q == (count_q - OneW);
    assign addr_sum  = {1'b0, base_q} + idx_q;
    assign issue_rd  = state_q == StRead;
    assign mismatch  = pipe_vld_q[READ_LATENCY-1] && (readdata != pipe_exp_q[READ_LATENCY-1]);
    assign pending   = |(pipe_vld_q & ~ExitMask);

    // Bus and status outputs decode directly from registered state.
    assign busy            = (state_q == StWrite) || (state_q == StRead) || (state_q == StDrain);
    assign done            = state_q == StDone;
    assign chipselect      = (state_q == StWrite) || (state_q == StRead);
    assign write           = state_q == StWrite;
    assign address         = addr_sum[ADDR_W-1:0];
    assign writedata       = seed_q + 32'(idx_q);
    assign byteenable      = 4'hF;
    assign pass            = pass_q;
    assign range_err       = range_err_q;
    assign error_count     = err_cnt_q;
    assign first_fail_addr = ff_addr_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        seed_d      = seed_q;
        pass_d      = pass_q;
        range_err_d = range_err_q;
        err_cnt_d   = err_cnt_q;
        ff_addr_d   = ff_addr_q;
        any_mis_d   = any_mis_q;

        // Compare runs in any state so reads in flight across READ->DRAIN are scored.
        if (mismatch) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            if (!any_mis_q) begin
                any_mis_d = 1'b1;
                ff_addr_d = pipe_addr_q[READ_LATENCY-1];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d      = base_addr;
                    count_d     = word_count;
                    seed_d      = seed;
                    idx_d       = '0;
                    err_cnt_d   = '0;
                    ff_addr_d   = '0;
                    any_mis_d   = 1'b0;
                    pass_d      = 1'b0;
                    range_err_d = 1'b0;
                    if (range_bad) begin
                        range_err_d = 1'b1;
                        state_d     = StDone;
                    end else if (word_count == '0) begin
                        pass_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (last_idx) begin
                    idx_d   = '0;
                    state_d = StRead;
                end else begin
                    idx_d = idx_q + OneW;
                end
            end
            StRead: begin
                // idx holds at the last word so address stays inside the range.
                if (last_idx) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + OneW;
                end
            end
            StDrain: begin
                if (!pending) begin
                    pass_d  = !(any_mis_q || mismatch);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            seed_q      <= '0;
            pass_q      <= 1'b0;
            range_err_q <= 1'b0;
            err_cnt_q   <= '0;
            ff_addr_q   <= '0;
            any_mis_q   <= 1'b0;
            pipe_vld_q  <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            seed_q        <= seed_d;
            pass_q        <= pass_d;
            range_err_q   <= range_err_d;
            err_cnt_q     <= err_cnt_d;
            ff_addr_q     <= ff_addr_d;
            any_mis_q     <= any_mis_d;
            pipe_vld_q[0] <= issue_rd;
            for (int k = 1; k < int'(READ_LATENCY); k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
            end
        end
    end

    // Payload needs no reset: it is only consumed alongside its valid bit.
    always_ff @(posedge clk) begin
        pipe_exp_q[0]  <= writedata;
        pipe_addr_q[0] <= address;
        for (int k = 1; k < int'(READ_LATENCY); k++) begin
            pipe_exp_q[k]  <= pipe_exp_q[k-1];
            pipe_addr_q[k] <= pipe_addr_q[k-1];
        end
    end

endmodule

// File: tb/tb_controller_ram_bist_master.sv
// Two instances (READ_LATENCY 1 and 3) run the same stimulus against a RAM model
// that can corrupt readback; results are predicted from the test rules alone.
module tb_controller_ram_bist_master;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DEPTH  = 12288;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] word_count;
    logic [31:0] seed;

    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic        range_err [2];
    logic [15:0] error_count [2];
    logic [13:0] first_fail_addr [2];
    logic [13:0] address [2];
    logic [3:0]  byteenable [2];
    logic        chipselect [2];
    logic        write [2];
    logic [31:0] writedata [2];
    logic [31:0] readdata [2];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        controller_ram_bist_master #(
            .ADDR_W       (ADDR_W),
            .DEPTH        (DEPTH),
            .READ_LATENCY ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .start           (start),
            .base_addr       (base_addr),
            .word_count      (word_count),
            .seed            (seed),
            .busy            (busy[g]),
            .done            (done[g]),
            .pass            (pass[g]),
            .range_err       (range_err[g]),
            .error_count     (error_count[g]),
            .first_fail_addr (first_fail_addr[g]),
            .address         (address[g]),
            .byteenable      (byteenable[g]),
            .chipselect      (chipselect[g]),
            .write           (write[g]),
            .writedata       (writedata[g]),
            .readdata        (readdata[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // RAM model: bits set in flip[addr] are inverted on readback.
    logic [31:0] mem   [2][DEPTH];
    logic [31:0] rpipe [2][3];
    logic [31:0] flip  [int];

    function automatic logic [31:0] flip_of(input int a);
        return flip.exists(a) ? flip[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (chipselect[g] && write[g]) mem[g][address[g]] <= writedata[g];
            rpipe[g][0] <= (chipselect[g] && !write[g]) ?
                           (mem[g][address[g]] ^ flip_of(int'(address[g]))) : 32'h0;
            rpipe[g][1] <= rpipe[g][0];
            rpipe[g][2] <= rpipe[g][1];
        end
    end
    assign readdata[0] = rpipe[0][0];
    assign readdata[1] = rpipe[1][2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected bus sequence of the current test; counters restart when test_id moves.
    int          test_id  = 0;
    int          exp_base = 0;
    int          exp_n    = 0;
    logic [31:0] exp_seed = 0;
    int last_id  [2] = '{0, 0};
    int wr_idx   [2] = '{0, 0};
    int rd_idx   [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int done_cyc [2] = '{0, 0};
    int busy_cyc [2] = '{0, 0};

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (last_id[g] != test_id) begin
                last_id[g]  = test_id;
                wr_idx[g]   = 0;
                rd_idx[g]   = 0;
                done_cnt[g] = 0;
                busy_cyc[g] = 0;
            end
            if (done[g]) begin
                done_cnt[g]++;
                done_cyc[g] = cyc;
            end
            if (busy[g]) busy_cyc[g]++;
            if (chipselect[g] && !reset) begin
                if (write[g]) begin
                    check_eq($sformatf("wr_addr[%0d]", g), 32'(address[g]),
                             32'(exp_base + wr_idx[g]));
                    check_eq($sformatf("wr_data[%0d]", g), writedata[g],
                             exp_seed + 32'(wr_idx[g]));
                    check_eq($sformatf("wr_be[%0d]", g), 32'(byteenable[g]), 32'hF);
                    wr_idx[g]++;
                end else begin
                    check_eq($sformatf("rd_addr[%0d]", g), 32'(address[g]),
                             32'(exp_base + rd_idx[g]));
                    check_eq($sformatf("rd_after_wr[%0d]", g), 32'(wr_idx[g]), 32'(exp_n));
                    rd_idx[g]++;
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("%s busy[%0d]", tag, g), 32'(busy[g]), 32'h0);
            check_eq($sformatf("%s done[%0d]", tag, g), 32'(done[g]), 32'h0);
            check_eq($sformatf("%s pass[%0d]", tag, g), 32'(pass[g]), 32'h0);
            check_eq($sformatf("%s range_err[%0d]", tag, g), 32'(range_err[g]), 32'h0);
            check_eq($sformatf("%s err_cnt[%0d]", tag, g), 32'(error_count[g]), 32'h0);
            check_eq($sformatf("%s ff_addr[%0d]", tag, g), 32'(first_fail_addr[g]), 32'h0);
            check_eq($sformatf("%s address[%0d]", tag, g), 32'(address[g]), 32'h0);
            check_eq($sformatf("%s be[%0d]", tag, g), 32'(byteenable[g]), 32'hF);
            check_eq($sformatf("%s cs[%0d]", tag, g), 32'(chipselect[g]), 32'h0);
            check_eq($sformatf("%s write[%0d]", tag, g), 32'(write[g]), 32'h0);
            check_eq($sformatf("%s wdata[%0d]", tag, g), writedata[g], 32'h0);
        end
    endtask

    task automatic run_test(input string tag, input int base, input int n, input logic [31:0] sd);
        bit ok;
        int errs;
        int ff;
        int s;
        ok   = (base + n) <= int'(DEPTH);
        errs = 0;
        ff   = 0;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                if (flip_of(base + i) != 0) begin
                    if (errs == 0) ff = base + i;
                    errs++;
                end
            end
        end
        @(negedge clk);
        exp_base   = base;
        exp_n      = n;
        exp_seed   = sd;
        test_id++;
        base_addr  = 14'(base);
        word_count = 15'(n);
        seed       = sd;
        start      = 1'b1;
        s          = cyc;
        @(negedge clk);
        start = 1'b0;
        if (ok && n > 0) begin
            // A start landing while busy must be ignored.
            repeat (2) @(negedge clk);
            start      = 1'b1;
            base_addr  = 14'($urandom);
            word_count = 15'($urandom_range(1, 5));
            seed       = $urandom;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < 2 * n + 20 && !(done_cnt[0] > 0 && done_cnt[1] > 0); k++) begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            int lat;
            lat = (ok && n > 0) ? (2 * n + lat_of(g) + 1) : 1;
            check_eq($sformatf("%s done_cnt[%0d]", tag, g), 32'(done_cnt[g]), 32'd1);
            check_eq($sformatf("%s latency[%0d]", tag, g), 32'(done_cyc[g] - s), 32'(lat));
            check_eq($sformatf("%s busy_cyc[%0d]", tag, g), 32'(busy_cyc[g]),
                     32'((ok && n > 0) ? (2 * n + lat_of(g)) : 0));
            check_eq($sformatf("%s writes[%0d]", tag, g), 32'(wr_idx[g]), 32'(ok ? n : 0));
            check_eq($sformatf("%s reads[%0d]", tag, g), 32'(rd_idx[g]), 32'(ok ? n : 0));
            check_eq($sformatf("%s pass[%0d]", tag, g), 32'(pass[g]), 32'(ok && errs == 0));
            check_eq($sformatf("%s range_err[%0d]", tag, g), 32'(range_err[g]), 32'(!ok));
            check_eq($sformatf("%s err_cnt[%0d]", tag, g), 32'(error_count[g]), 32'(errs));
            check_eq($sformatf("%s ff_addr[%0d]", tag, g), 32'(first_fail_addr[g]), 32'(ff));
            check_eq($sformatf("%s busy_end[%0d]", tag, g), 32'(busy[g]), 32'h0);
        end
        flip.delete();
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        seed       = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("por");

        run_test("ideal16", 0, 16, 32'h1000_0000);

        flip[5] = 32'h1;
        flip[9] = 32'h1;
        run_test("corrupt5_9", 0, 16, 32'h1000_0000);

        run_test("range9", 12280, 9, 32'hA5A5_0000);
        run_test("range8", 12280, 8, 32'hA5A5_0000);
        run_test("count0", 77, 0, 32'h1234_5678);

        // Reset while both instances are issuing read i=3.
        begin
            int s;
            @(negedge clk);
            exp_base   = 200;
            exp_n      = 8;
            exp_seed   = 32'hCAFE_0000;
            test_id++;
            base_addr  = 14'd200;
            word_count = 15'd8;
            seed       = 32'hCAFE_0000;
            start      = 1'b1;
            s          = cyc;
            @(negedge clk);
            start = 1'b0;
            repeat (8 + 3) @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check_eq($sformatf("mid cs[%0d]", g), 32'(chipselect[g] && !write[g]), 32'h1);
                check_eq($sformatf("mid addr[%0d]", g), 32'(address[g]), 32'd203);
            end
            reset = 1'b1;
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check_eq($sformatf("rst cs[%0d]", g), 32'(chipselect[g]), 32'h0);
                check_eq($sformatf("rst busy[%0d]", g), 32'(busy[g]), 32'h0);
            end
            reset = 1'b0;
            repeat (10) @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check_eq($sformatf("rst no_done[%0d]", g), 32'(done_cnt[g]), 32'h0);
            end
            check_reset_vals("midrst");
        end
        run_test("after_rst", 300, 6, 32'h0BAD_F00D);

        for (int a = 500; a < 504; a++) flip[a] = 32'h8000_0001;
        run_test("wrap_allbad", 500, 4, 32'hFFFF_FFFE);

        for (int t = 0; t < 10; t++) begin
            int b;
            int n;
            b = ($urandom_range(0, 1) == 0) ? $urandom_range(12250, 12287)
                                            : $urandom_range(0, 12287);
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) flip[b + i] = 32'h1 << $urandom_range(0, 31);
            end
            run_test($sformatf("rnd%0d", t), b, n, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/controller_ram_bist_master.md
Name: controller_ram_bist_master

Overview:
- Avalon-MM initiator that drives the single-port on-chip RAM slave (s1) for built-in self-test and fill.
- Writes an incrementing 32-bit pattern over a requested word range, reads the range back with pipelined fixed-latency reads, and compares each returned word.
- Reports pass/fail, mismatch count and first failing address to the controller CSR block.
- Sits between the controller's test CSR logic and the RAM's s1 port.

Parameters:
- ADDR_W, 14, word-address width of the RAM port.
- DEPTH, 12288, number of valid 32-bit words in the RAM.
- READ_LATENCY, 1, cycles from read issue to valid readdata (1..4).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a test; sampled only in IDLE
- base_addr  in  ADDR_W  first word address
- word_count  in  ADDR_W+1  number of words to test
- seed  in  32  pattern value for word 0
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at test end
- pass  out  1  result of the last test; held until the next accepted start
- range_err  out  1  last start was rejected (base_addr+word_count > DEPTH)
- error_count  out  16  mismatches in the last test, saturating
- first_fail_addr  out  ADDR_W  address of the first mismatch
- address  out  ADDR_W  to RAM s1
- byteenable  out  4  to RAM s1
- chipselect  out  1  to RAM s1
- write  out  1  to RAM s1
- writedata  out  32  to RAM s1
- readdata  in  32  from RAM s1

Behaviour:
- Reset (synchronous, registered):
  - All outputs are 0, except byteenable, which is 4'hF; state goes to IDLE.
  - Reset mid-test aborts on the next edge: chipselect and write drop, and in-flight reads are discarded.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - On start, latch base_addr, word_count and seed.
  - Clear error_count, first_fail_addr, pass and range_err.
  - If base_addr+word_count > DEPTH (computed at ADDR_W+1 bits): set range_err=1, pass=0, go to DONE.
  - Else if word_count==0: pass=1, go to DONE.
  - Else go to WRITE with index i=0.
- WRITE:
  - Each cycle: chipselect=1, write=1, address=base+i, writedata=seed+i (mod 2^32), byteenable=4'hF.
  - After word_count-1 is issued, go to READ with i=0.
  - There are no wait states: the slave accepts one access per cycle.
- READ:
  - Each cycle: chipselect=1, write=0, address=base+i.
  - Push expected=seed+i and addr into a READ_LATENCY-deep valid/expected/addr shift pipeline.
  - After the last issue, go to DRAIN.
- Compare:
  - A pipeline entry exiting with valid=1 compares readdata against its expected value.
  - On mismatch: error_count increments, saturating at 16'hFFFF.
  - If it is the first mismatch of the test, first_fail_addr is set to that entry's addr.
- DRAIN:
  - chipselect=0; wait until the pipeline holds no valid entries, then set pass=(no mismatch) and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- busy timing:
  - busy=1 in WRITE, READ and DRAIN.
  - busy=0 in IDLE and DONE.
- start received while not in IDLE is ignored.
- Total latency for N>0: 1 (IDLE accept) + N write + N read + READ_LATENCY drain + 1 DONE.
- Address is never outside [base, base+N-1]; after the range check there is no wrap.
- Back-to-back: start in the cycle after done is accepted.

Test Plan:
- base=0, count=16, seed=32'h1000_0000, ideal RAM model -> 16 writes with data 0x10000000..0x1000000F, 16 reads, done after 16+16+1+1+1 = 35 cycles, pass=1, error_count=0.
- Same run with the model corrupting bit 0 of words 5 and 9 on readback -> pass=0, error_count=2, first_fail_addr=5.
- base=12280, count=9 -> no chipselect asserted, range_err=1, pass=0, done 1 cycle after start; then base=12280, count=8 -> passes with last address 12287.
- count=0 -> done pulse next cycle, pass=1, no bus activity.
- Reset asserted during READ (i=3) -> next cycle chipselect=0, busy=0, done never pulses; a fresh start then completes normally.
- READ_LATENCY=3, count=4, every read corrupted; seed=32'hFFFF_FFFE -> writedata wraps to 0 and 1, error_count=4, start pulsed while busy is ignored.
